bin2bcd: RTL

- Sequential binary-to-packed-BCD converter (shift-add-3 / double-dabble), one bit per clock.
- Sits downstream of the bcd2bin core and the calculator ALU: converts the 16-bit binary result into 5 BCD digits for the display peripheral.
- Uses the same init/done/result core handshake as bcd2bin, so the CPU-side peripheral wrapper can drive it through memory-mapped registers.

---
 rtl/bin2bcd_pkg.sv | 24 ++
 rtl/bin2bcd_add3.sv | 19 +
 rtl/bin2bcd.sv | 139 +++++++++++++
 3 files changed

// File: rtl/bin2bcd_pkg.sv
`default_nettype none
//==============================================================================
// Module  : bin2bcd_pkg
// Purpose : Shared constants for the bin2bcd converter. Holds the default
//           geometry, the FSM state encoding and the default counter width.
// Macros  : none (the optional BIN2BCD_SIGN_EN feature lives in bin2bcd.sv)
// Revision: 1.0 - initial release
//==============================================================================
package bin2bcd_pkg;

    // Default geometry: 16-bit binary fits in 5 BCD digits (max 65535).
    localparam int c_DEF_WIDTH  = 16;
    localparam int c_DEF_DIGITS = 5;

    // Counter must be able to hold the value WIDTH.
    localparam int c_CNT_W      = $clog2(c_DEF_WIDTH + 1);

    // FSM state encoding
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

endpackage : bin2bcd_pkg
`default_nettype wire

// File: rtl/bin2bcd_add3.sv
`default_nettype none
//==============================================================================
// Module  : bin2bcd_add3
// Purpose : Double-dabble nibble corrector. A BCD nibble of 5 or more gets +3
//           so that the following left shift carries correctly into the next
//           decimal digit.
// Ports   : i_nib [3:0] - BCD nibble before correction
//           o_nib [3:0] - corrected nibble (never exceeds 12, no carry out)
// Revision: 1.0 - initial release
//==============================================================================
module bin2bcd_add3 (
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);

    assign o_nib = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;

endmodule : bin2bcd_add3
`default_nettype wire

// File: rtl/bin2bcd.sv
`default_nettype none
//==============================================================================
// Module  : bin2bcd
// Purpose : Sequential binary to packed-BCD converter (shift-add-3), one bit
//           per clock. done rises WIDTH edges after the edge that sampled
//           init, and result only changes on that same edge.
// Ports   : clk    - system clock, rising edge
//           rst    - asynchronous reset, active low
//           init   - level start request, sampled in IDLE
//           A      - binary operand, sampled only on the start edge
//           result - packed BCD, digit 0 in [3:0]
//           done   - high while the FSM is in DONE
//           sign   - operand sign (only with BIN2BCD_SIGN_EN)
// Macros  : BIN2BCD_SIGN_EN - treat A as two's complement; convert the
//           magnitude and report the sign on the sign port.
// Revision: 1.0 - initial release
//==============================================================================
module bin2bcd
    import bin2bcd_pkg::*;
#(
    parameter int WIDTH  = c_DEF_WIDTH,
    parameter int DIGITS = c_DEF_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init,
    input  logic [WIDTH-1:0]      A,
    output logic [4*DIGITS-1:0]   result,
    output logic                  done
`ifdef BIN2BCD_SIGN_EN
    ,
    output logic                  sign
`endif
);

    localparam int c_BCD_W     = 4 * DIGITS;
    localparam int c_SR_W      = c_BCD_W + WIDTH;
    localparam int c_CNT_WIDTH = $clog2(WIDTH + 1);

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [c_SR_W-1:0]      r_sr;          // {BCD field, binary field}
    logic [c_SR_W-1:0]      w_sr_load;
    logic [c_SR_W-1:0]      w_sr_corr;
    logic [c_SR_W-1:0]      w_sr_shift;
    logic [c_CNT_WIDTH-1:0] r_cnt;
    logic                   w_last;

    // Value loaded into the shift register on the start edge.
`ifdef BIN2BCD_SIGN_EN
    logic             r_sign_ld;
    logic [WIDTH:0]   w_ext;
    logic [WIDTH:0]   w_mag;

    // Negation is done one bit wider so -2^(WIDTH-1) yields +2^(WIDTH-1),
    // which still fits in the WIDTH-bit binary field as an unsigned value.
    assign w_ext     = {A[WIDTH-1], A};
    assign w_mag     = A[WIDTH-1] ? (~w_ext + 1'b1) : w_ext;
    assign w_sr_load = {{c_BCD_W{1'b0}}, w_mag[WIDTH-1:0]};
`else
    assign w_sr_load = {{c_BCD_W{1'b0}}, A};
`endif

    // All BCD digits are corrected in parallel; the binary field passes.
    assign w_sr_corr[WIDTH-1:0] = r_sr[WIDTH-1:0];

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bin2bcd_add3 u_add3 (
            .i_nib (r_sr[WIDTH + 4*g +: 4]),
            .o_nib (w_sr_corr[WIDTH + 4*g +: 4])
        );
    end

    // Shift carries each nibble's MSB into the next nibble up.
    assign w_sr_shift = w_sr_corr << 1;

    assign w_last = (r_cnt == c_CNT_WIDTH'(WIDTH - 1));

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (init)   w_state_nxt = c_SHIFT;
            c_SHIFT: if (w_last) w_state_nxt = c_DONE;
            c_DONE:  if (!init)  w_state_nxt = c_IDLE;
            default:             w_state_nxt = c_IDLE;
        endcase
    end

    assign done = (r_state == c_DONE);

    // Datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sr   <= '0;
            r_cnt  <= '0;
            result <= '0;
`ifdef BIN2BCD_SIGN_EN
            r_sign_ld <= 1'b0;
            sign      <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (init) begin
                        r_sr  <= w_sr_load;
                        r_cnt <= '0;
`ifdef BIN2BCD_SIGN_EN
                        r_sign_ld <= A[WIDTH-1];
`endif
                    end
                end
                c_SHIFT: begin
                    r_sr  <= w_sr_shift;
                    r_cnt <= r_cnt + 1'b1;
                    // Publish only the final value so partial sums stay hidden.
                    if (w_last) begin
                        result <= w_sr_shift[c_SR_W-1 -: c_BCD_W];
`ifdef BIN2BCD_SIGN_EN
                        sign   <= r_sign_ld;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : bin2bcd
`default_nettype wire
